// File: rtl/key_schedule_5r.sv
// Iterative round-key generator: expands a 128-bit master key into five round keys,
// one round per clock, and holds them with a level valid until the next start or reset.
module key_schedule_5r #(
  parameter int unsigned ROUND    = 5,
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tvalid,
  input  logic [KEY_SIZE-1:0] key,
  output logic                valid,
  output logic [KEY_SIZE-1:0] K0,
  output logic [KEY_SIZE-1:0] K1,
  output logic [KEY_SIZE-1:0] K2,
  output logic [KEY_SIZE-1:0] K3,
  output logic [KEY_SIZE-1:0] K4
);

  localparam logic [31:0] RC1 = 32'h9E3779B9;
  localparam logic [31:0] RC2 = 32'h3C6EF372;
  localparam logic [31:0] RC3 = 32'hDAA66D2B;
  localparam logic [31:0] RC4 = 32'h78DDE6E4;
  localparam logic [2:0]  LastRound = 3'(ROUND - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [2:0]          round_q;
  logic                valid_q;
  logic [KEY_SIZE-1:0] k0_q, k1_q, k2_q, k3_q, k4_q;

  logic [KEY_SIZE-1:0] prev_key;
  logic [KEY_SIZE-1:0] f_out;
  logic [31:0]         rc;
  logic [31:0]         w0, w1, w2, w3;
  logic [31:0]         fa, fb, fc, fd;

  // Select the previous round key and the constant for the round being computed.
  always_comb begin
    prev_key = k0_q;
    rc       = RC1;
    unique case (round_q)
      3'd1: begin prev_key = k0_q; rc = RC1; end
      3'd2: begin prev_key = k1_q; rc = RC2; end
      3'd3: begin prev_key = k2_q; rc = RC3; end
      3'd4: begin prev_key = k3_q; rc = RC4; end
      default: begin prev_key = k0_q; rc = RC1; end
    endcase
  end

  // Round function F: ARX mixing of the four 32-bit words.
  always_comb begin
    w0 = prev_key[127:96];
    w1 = prev_key[95:64];
    w2 = prev_key[63:32];
    w3 = prev_key[31:0];
    fa = w0 ^ {w3[24:0], w3[31:25]} ^ rc;
    fb = w1 + fa;
    fc = w2 ^ {fb[18:0], fb[31:19]};
    fd = w3 + fc;
    f_out = {fb, fc, fd, fa};
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= StIdle;
      round_q <= 3'd0;
      valid_q <= 1'b0;
      k0_q    <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      k4_q    <= '0;
    end else if (tvalid) begin
      // A start in any state discards whatever schedule was in flight.
      state_q <= StBusy;
      round_q <= 3'd1;
      valid_q <= 1'b0;
      k0_q    <= key;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      k4_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StIdle;
        end
        StBusy: begin
          case (round_q)
            3'd1:    k1_q <= f_out;
            3'd2:    k2_q <= f_out;
            3'd3:    k3_q <= f_out;
            3'd4:    k4_q <= f_out;
            default: ;
          endcase
          if (round_q == LastRound) begin
            valid_q <= 1'b1;
            state_q <= StIdle;
            round_q <= 3'd0;
          end else begin
            round_q <= round_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid = valid_q;
  assign K0    = k0_q;
  assign K1    = k1_q;
  assign K2    = k2_q;
  assign K3    = k3_q;
  assign K4    = k4_q;

endmodule

// File: tb/tb_key_schedule_5r.sv
// Self-checking bench for key_schedule_5r: known-answer table, directed corner sequences
// and random keys, all checked against a word-level model of the key schedule.
module tb_key_schedule_5r;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tvalid;
  logic [127:0] key;
  logic         valid;
  logic [127:0] K0, K1, K2, K3, K4;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_k [5];

  key_schedule_5r dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tvalid  (tvalid),
    .key     (key),
    .valid   (valid),
    .K0      (K0),
    .K1      (K1),
    .K2      (K2),
    .K3      (K3),
    .K4      (K4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic         has_k1;
    logic [127:0] k1;
  } vec_t;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rconst(input int i);
    case (i)
      1: return 32'h9E3779B9;
      2: return 32'h3C6EF372;
      3: return 32'hDAA66D2B;
      default: return 32'h78DDE6E4;
    endcase
  endfunction

  function automatic logic [127:0] model_f(input logic [127:0] x, input int i);
    logic [31:0] a, b, c, d;
    a = x[127:96] ^ rotl(x[31:0], 7) ^ rconst(i);
    b = x[95:64] + a;
    c = x[63:32] ^ rotl(b, 13);
    d = x[31:0] + c;
    return {b, c, d, a};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    exp_k[0] = k;
    for (int i = 1; i < 5; i++) exp_k[i] = model_f(exp_k[i-1], i);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_keys(input string name);
    check({name, " valid"}, 128'(valid), 128'd1);
    check({name, " K0"}, K0, exp_k[0]);
    check({name, " K1"}, K1, exp_k[1]);
    check({name, " K2"}, K2, exp_k[2]);
    check({name, " K3"}, K3, exp_k[3]);
    check({name, " K4"}, K4, exp_k[4]);
  endtask

  // Single pulse, then step through the schedule checking latency and final keys.
  task automatic run_key(input logic [127:0] k, input string name);
    model_expand(k);
    key    = k;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    key    = {$urandom, $urandom, $urandom, $urandom};
    check({name, " accept valid"}, 128'(valid), 128'd0);
    check({name, " accept K0"}, K0, k);
    check({name, " accept K1..K4"}, K1 | K2 | K3 | K4, 128'd0);
    for (int c = 1; c < 4; c++) begin
      tick();
      check({name, " early valid"}, 128'(valid), 128'd0);
    end
    tick();
    check_keys(name);
  endtask

  vec_t vecs [3];

  initial begin
    vecs[0] = '{128'h0, 1'b1, 128'h9E3779B9_EF3733C6_EF3733C6_9E3779B9};
    vecs[1] = '{128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333, 1'b0, 128'h0};
    vecs[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 128'h0};

    // Reset with tvalid high must not start a schedule.
    reset_n = 1'b1;
    tvalid  = 1'b1;
    key     = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    tick();
    tick();
    reset_n = 1'b0;
    tvalid  = 1'b0;
    check("reset valid", 128'(valid), 128'd0);
    check("reset keys", K0 | K1 | K2 | K3 | K4, 128'd0);
    tick();
    check("post-reset valid", 128'(valid), 128'd0);
    check("post-reset K0", K0, 128'd0);

    // Known-answer table plus hold behaviour.
    foreach (vecs[v]) begin
      run_key(vecs[v].key, $sformatf("vec%0d", v));
      if (vecs[v].has_k1) check("kat K1", K1, vecs[v].k1);
      for (int c = 0; c < 10; c++) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        tick();
        check_keys($sformatf("hold%0d", v));
      end
    end

    // Restarts every 3 cycles: valid only after the last pulse.
    begin
      logic [127:0] bk [4];
      bk[0] = 128'h11112222_33334444_55556666_77778888;
      bk[1] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      bk[2] = 128'hCAFEBABE_DEADBEEF_12345678_90ABCDEF;
      bk[3] = 128'hFACEFACE_12345678_A1B2C3D4_E5F60718;
      for (int p = 0; p < 3; p++) begin
        key    = bk[p];
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
          check("b2b valid low", 128'(valid), 128'd0);
          tick();
        end
      end
      run_key(bk[3], "b2b final");
    end

    // tvalid held high for several cycles with changing keys.
    for (int c = 0; c < 3; c++) begin
      key    = {$urandom, $urandom, $urandom, $urandom};
      tvalid = 1'b1;
      tick();
      check("held valid low", 128'(valid), 128'd0);
    end
    run_key(128'h0BADF00D_DEADC0DE_55AA55AA_C0FFEE00, "held last");

    // Reset at edge N+2 aborts the schedule.
    key    = 128'h13579BDF_2468ACE0_F0E1D2C3_B4A59687;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    check("midreset keys", K0 | K1 | K2 | K3 | K4, 128'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("midreset valid", 128'(valid), 128'd0);
      check("midreset K4", K4, 128'd0);
    end
    run_key(128'h13579BDF_2468ACE0_F0E1D2C3_B4A59687, "after reset");

    // New key after completion; run_key checks the drop at the accepting edge.
    run_key(128'hA5A5A5A5_5A5A5A5A_00000001_80000000, "second key");

    // Random keys with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      run_key({$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", n));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      check_keys("rand hold");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/key_schedule_5r.md
Name: key_schedule_5r

Overview:
- Iterative round-key generator for the chaos-based symmetric image cipher.
- Expands one 128-bit master key into five 128-bit round keys K0..K4, computing one round per clock.
- Holds all five keys on parallel outputs, with a level `valid`, for the encryption/decryption datapath.

Parameters:
ROUND, 5, number of round keys produced; the RTL supports only 5 (K0..K4 ports are fixed).
KEY_SIZE, 128, master/round key width; the RTL supports only 128 (four 32-bit words).

Ports:
clk      input   1         rising-edge clock.
reset_n  input   1         synchronous active-high reset. The port keeps the codebase name despite the _n suffix: reset is asserted when reset_n=1.
tvalid   input   1         single-cycle start strobe; qualifies `key`.
key      input   KEY_SIZE  master key, sampled when tvalid=1.
valid    output  1         high when K0..K4 are complete and stable.
K0..K4   output  KEY_SIZE  round keys, each registered.

Behaviour:
- Clocking and reset:
  - One clock domain; all state updates on the rising edge of clk.
  - Reset is synchronous: if reset_n=1 at an edge, valid=0, K0..K4=0, round counter=0, FSM=IDLE.
  - Reset has priority over tvalid.
- Word view: X = {w0,w1,w2,w3}, w0 = bits [127:96]. rotl(v,n) is a 32-bit rotate left. All additions are mod 2^32.
- Round constants:
  - RC1=32'h9E3779B9
  - RC2=32'h3C6EF372
  - RC3=32'hDAA66D2B
  - RC4=32'h78DDE6E4
- Round function F(X,i), purely combinational:
  - a = w0 ^ rotl(w3,7) ^ RCi
  - b = w1 + a
  - c = w2 ^ rotl(b,13)
  - d = w3 + c
  - F = {b, c, d, a}
- Schedule: K0 = key; Ki = F(K(i-1), i) for i = 1..4.
- FSM states:
  - IDLE: no key in progress, or keys already done.
  - BUSY: counter r = 1..4.
- Transitions and timing (edge N = the edge where tvalid=1 is sampled):
  - Edge N, any state: K0<=key, K1..K4<=0, valid<=0, r<=1, go to BUSY.
  - Edges N+1 .. N+4: K_r <= F(K_(r-1), r), then r <= r+1.
  - Edge N+4: K4 is written, valid<=1, go to IDLE.
  - Latency: valid is observed high 4 cycles after the accepting edge.
- Hold behaviour:
  - valid is a level, not a pulse.
  - valid and K0..K4 stay constant indefinitely until the next accepted tvalid or reset.
- tvalid while BUSY:
  - Aborts the current schedule and restarts with the new key, exactly as at edge N.
  - No partial result is ever flagged valid.
- tvalid held high for several cycles: each cycle restarts, so valid rises 4 cycles after the last tvalid=1 edge.
- No backpressure; `key` is only sampled on tvalid edges, so it may change freely otherwise.

Test Plan:
1. Reset: hold reset_n=1 for 2 cycles with tvalid=1 -> valid=0 and K0..K4=0 after reset, no start occurs.
2. key=0, one tvalid pulse -> exactly 4 cycles later valid=1, K0=0, and K1=9E3779B9_EF3733C6_EF3733C6_9E3779B9. K2..K4 match a bit-exact software model of F.
3. key=AAAABBBB_CCCC1111_DDDD2222_EEEE3333 -> K0 equals key. K1..K4 match the model. valid is 0 for the 4 cycles before it rises, then stays 1 for 10 or more idle cycles with all outputs unchanged.
4. Back-to-back restart: send pulses of 11112222_33334444_55556666_77778888, 01234567_89ABCDEF_FEDCBA98_76543210, CAFEBABE_DEADBEEF_12345678_90ABCDEF and FACEFACE_12345678_A1B2C3D4_E5F60718, each 3 cycles apart -> valid never rises until 4 cycles after the last pulse. Final K0 = FACEFACE_12345678_A1B2C3D4_E5F60718 and K1..K4 match the model for that key.
5. Reset mid-schedule: pulse tvalid, assert reset_n=1 at edge N+2 -> all outputs 0 and valid stays 0. A fresh tvalid afterwards produces the correct keys with 4-cycle latency.
6. New key after done: keys valid from a first key, then pulse a second key -> valid drops at the accepting edge, K1..K4=0 on the next cycle, and the new set becomes valid 4 cycles after the accepting edge.
